// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the single-port memory arbiter:
//   arb_state_t : transaction sequencer state (IDLE, WAIT)
//   req_id_t    : requester identity (FETCH, DATA)
//   FUNCT3_WORD : access size forced on the memory port for instruction fetches
//   MAX_LATENCY : largest supported memory read latency
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } req_id_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;
  localparam int         MAX_LATENCY = 4;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-input round-robin picker. While enabled, a lone requester is picked;
// on a tie the requester that did not win the previous pick is chosen.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   en               : arbitration allowed this cycle (port free)
//   f_req, d_req     : fetch / data requests
//   f_pick, d_pick   : one-hot pick (combinational), never both high
import mem_arb_pkg::*;

module rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic f_req,
  input  logic d_req,
  output logic f_pick,
  output logic d_pick
);

  req_id_t last_grant;

  always_comb begin
    f_pick = 1'b0;
    d_pick = 1'b0;
    if (en) begin
      if (f_req && d_req) begin
        if (last_grant == FETCH) d_pick = 1'b1;
        else                     f_pick = 1'b1;
      end else begin
        f_pick = f_req;
        d_pick = d_req;
      end
    end
  end

  // Resets to FETCH so that DATA wins the first tie after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= FETCH;
    end else if (d_pick) begin
      last_grant <= DATA;
    end else if (f_pick) begin
      last_grant <= FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between the instruction-fetch and load/store
// requesters. One transaction in flight; completion is a registered pulse
// MEM_LATENCY cycles after the grant, routed to the requester that owned it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight, port free for a grant
// WAIT  | access in flight; last WAIT cycle is the done cycle, in
//       | which the port is free again for a back-to-back grant
//
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   f_req/f_addr                  : fetch request and byte address
//   f_gnt/f_done/f_rdata/f_misalign : fetch accept, completion, data, misalign flag
//   d_req/d_we/d_addr/d_wdata/d_funct3 : data request fields
//   d_gnt/d_done/d_rdata          : data accept, completion, load data
//   mem_address/mem_data_in/mem_wren/mem_funct3 : shared port drive
//   mem_data_out                  : shared port read data
// MEM_LATENCY legal range is 1..MAX_LATENCY.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_done,
  output logic [31:0] f_rdata,
  output logic        f_misalign,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_wren,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_data_out
);

  // Counter value in the done cycle; it counts WAIT cycles starting at 0.
  localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

  arb_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  req_id_t    owner_q, owner_d;
  logic       we_q;
  logic       mis_q;
  logic       f_done_q;
  logic       d_done_q;

  logic done_cycle;
  logic free;
  logic gnt;
  logic f_mis_now;
  logic done_arm;

  assign done_cycle = (state_q == WAIT) && (cnt_q == LAST_CNT);
  assign free       = (state_q == IDLE) || done_cycle;
  assign gnt        = f_gnt | d_gnt;
  assign f_mis_now  = (f_addr[1:0] != 2'b00);

  rr_arb2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (free),
    .f_req   (f_req),
    .d_req   (d_req),
    .f_pick  (f_gnt),
    .d_pick  (d_gnt)
  );

  // Memory port is driven only in the grant cycle. A misaligned fetch still
  // takes its slot but presents address 0 and never writes.
  always_comb begin
    mem_address = 32'h0;
    mem_data_in = 32'h0;
    mem_wren    = 1'b0;
    mem_funct3  = 3'b000;
    if (d_gnt) begin
      mem_address = d_addr;
      mem_data_in = d_wdata;
      mem_wren    = d_we;
      mem_funct3  = d_funct3;
    end else if (f_gnt) begin
      mem_address = f_mis_now ? 32'h0 : f_addr;
      mem_funct3  = FUNCT3_WORD;
    end
  end

  // A grant in the done cycle restarts WAIT directly; the counter never wraps
  // because the done cycle always leaves or restarts WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    if (gnt) begin
      state_d = WAIT;
      cnt_d   = 3'd0;
      owner_d = d_gnt ? DATA : FETCH;
    end else if (done_cycle) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else if (state_q == WAIT) begin
      cnt_d   = 3'(cnt_q + 3'd1);
    end
    done_arm = (state_d == WAIT) && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      owner_q  <= FETCH;
      we_q     <= 1'b0;
      mis_q    <= 1'b0;
      f_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      if (gnt) begin
        we_q  <= d_gnt & d_we;
        mis_q <= f_gnt & f_mis_now;
      end
      f_done_q <= done_arm && (owner_d == FETCH);
      d_done_q <= done_arm && (owner_d == DATA);
    end
  end

  assign f_done     = f_done_q;
  assign d_done     = d_done_q;
  assign f_misalign = f_done_q & mis_q;
  assign f_rdata    = (f_done_q && !mis_q) ? mem_data_out : 32'h0;
  assign d_rdata    = (d_done_q && !we_q)  ? mem_data_out : 32'h0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and transaction sequencer between the instruction-fetch requester and the load/store requester of the multi-cycle RV32I core. It owns the one shared port of the memory block (the port that also serves the LED/RGB MMIO). It arbitrates round-robin, holds one transaction in flight, counts the fixed memory read latency and returns a per-requester completion pulse with data. It lets the core drive a single-ported memory image instead of separate imem/dmem ports.

## Interface
- `MEM_LATENCY`, default 1: cycles from grant to read data valid at `mem_data_out`. Legal range 1..4.
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `f_req` input 1: fetch request. Hold high with stable `f_addr` until `f_gnt`.
- `f_addr` input 32: fetch byte address.
- `f_gnt` output 1: fetch accepted this cycle.
- `f_done` output 1: fetch completion pulse.
- `f_rdata` output 32: instruction word, valid only while `f_done`.
- `f_misalign` output 1: asserted with `f_done` when `f_addr[1:0]` ≠ 0.
- `d_req` input 1: data request. Hold with stable fields until `d_gnt`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input 32: data byte address.
- `d_wdata` input 32: store data.
- `d_funct3` input 3: access size/sign, passed to memory.
- `d_gnt` output 1: data accepted.
- `d_done` output 1: data completion pulse.
- `d_rdata` output 32: load data, valid only while `d_done`.
- `mem_address` output 32: shared port address.
- `mem_data_in` output 32: shared port write data.
- `mem_wren` output 1: shared port write enable.
- `mem_funct3` output 3: shared port access size.
- `mem_data_out` input 32: shared port read data.

## Operation
- States: IDLE, WAIT.
  - IDLE →(any grant)→ WAIT.
  - WAIT →(latency counter reaches MEM_LATENCY)→ IDLE, or straight back into WAIT if a new grant occurs in the same done cycle.
- Arbiter is free in IDLE and in the done cycle of WAIT. At most one grant per free cycle; never both `f_gnt` and `d_gnt`.
- Arbitration:
  - Single requester: it is granted.
  - Both requesting: grant the requester that did not win the previous grant. `last_grant` resets to FETCH, so data wins the first tie.
- Memory drive:
  - In the grant cycle only, `mem_*` carry the granted requester's fields.
  - Fetch forces `mem_wren` = 0 and `mem_funct3` = 3'b010.
  - Outside a grant cycle: `mem_wren` = 0, address/data/funct3 = 0.
- Misaligned fetch: granted normally, but `mem_address` is driven 0 and `mem_wren` 0. `f_done` still arrives on schedule, with `f_misalign` = 1 and `f_rdata` = 0.
- Stores: `mem_wren` is high for exactly the grant cycle. `d_done` follows on the same MEM_LATENCY schedule; `d_rdata` = 0 for stores.
- Completion: owner id and we-flag are latched at grant. `done` is asserted only to the latched owner. `rdata` = `mem_data_out` gated by the owner's `done`, otherwise 0.
- Reset mid-transaction: the in-flight access is dropped and no `done` is issued. State → IDLE, counter → 0, `last_grant` → FETCH.

## Timing
- Reset values: all `gnt`/`done`/`f_misalign` = 0, `rdata` = 0, `mem_wren` = 0, `mem_address`/`mem_data_in`/`mem_funct3` = 0.
- `gnt` and `mem_*` are combinational from `req` and registered state, in the same cycle.
- Grant in cycle T → `done` is a registered single-cycle pulse in cycle T+MEM_LATENCY.
- Back-to-back: a new grant is allowed in cycle T+MEM_LATENCY. Peak throughput is one transaction per MEM_LATENCY cycles.
- Latency counter: 3 bits, cleared on grant, saturates only via the state transition (no wrap).
- A request dropped before `gnt` is a protocol violation and is not checked.

## Structure
- `mem_arb_pkg`:
  - `arb_state_t` {IDLE, WAIT}
  - `req_id_t` {FETCH, DATA}
  - `FUNCT3_WORD` = 3'b010
  - `MAX_LATENCY` = 4
- Sub-module `rr_arb2`: two-input round-robin pick with registered `last_grant`, enable = free.
- All other logic (FSM, counter, owner latch, muxes) lives in `mem_arbiter`.

## Test plan
- Fetch alone, MEM_LATENCY = 1, `f_addr` = 0x1000, memory word 0x00500093 → `f_gnt` in cycle 0, `f_done` and `f_rdata` = 0x00500093 in cycle 1.
- `d_req` and `f_req` rise together after reset → `d_gnt` first. Holding both → grants alternate D, F, D, F, each `done` MEM_LATENCY later.
- Store `d_addr` = 0x2000, `d_wdata` = 0xDEADBEEF, `d_funct3` = 3'b010 → `mem_wren` high for the grant cycle only. Subsequent load of 0x2000 returns 0xDEADBEEF.
- MEM_LATENCY = 3, continuous fetch requests → one grant every 3 cycles, with a `done` and new grant in the same cycle.
- `f_addr` = 0x1002 → `f_done` with `f_misalign` = 1, `f_rdata` = 0, no write on the memory port.
- `reset_n` low in the cycle after a load grant → no `d_done`. After release, the first tie goes to DATA.
